// File: rtl/attn_pkg.sv
// Shared types and helpers for the attention row accumulator.
// Optional build macro ATTN_ACC_SAT_EN (used by attn_row_accum) selects saturating accumulation.
package attn_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  localparam int unsigned ACC_WIDTH_DEFAULT = 32;

  // Signed add of two values sign-extended to 64 bits, clamped to a signed w-bit range.
  // The result is returned sign-extended to 64 bits; w must be at most 63.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned       w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (s > hi) begin
      return hi[63:0];
    end else if (s < lo) begin
      return lo[63:0];
    end
    return s[63:0];
  endfunction

endpackage

// File: rtl/row_adder_tree.sv
// Sums one lane's NUM_MACS signed products, sign-extended to ACC_WIDTH.
module row_adder_tree #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_MACS   = 4,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic [NUM_MACS*2*DATA_WIDTH-1:0] prod,
  output logic signed [ACC_WIDTH-1:0]      sum
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  // Combinational sum of all products in the lane.
  always_comb begin
    sum = '0;
    for (int j = 0; j < int'(NUM_MACS); j++) begin
      sum = sum + ACC_WIDTH'(signed'(prod[j*PW +: PW]));
    end
  end

endmodule

// File: rtl/attn_row_accum.sv
// Per-lane accumulation of product beats into one signed result per vector.
// Build macro ATTN_ACC_SAT_EN: when defined, accumulator updates saturate (sticky per vector);
// otherwise they wrap modulo 2^ACC_WIDTH.
module attn_row_accum
  import attn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_MACS     = 4,
  parameter int unsigned NUM_ATTN_PES = 4,
  parameter int unsigned ACC_WIDTH    = ACC_WIDTH_DEFAULT,
  parameter int unsigned MAX_LEN      = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NUM_MACS*NUM_ATTN_PES*2*DATA_WIDTH-1:0] in_prod,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_ATTN_PES*ACC_WIDTH-1:0]      out_acc,
  output logic                                   len_err
);

  localparam int unsigned LANE_W = 2 * NUM_MACS * DATA_WIDTH;
  localparam int unsigned CNT_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             len_err_q;
  logic             accept, first, at_cap, fin;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign len_err   = len_err_q;

  assign accept = in_valid && in_ready;
  assign first  = (state_q == IDLE);
  assign at_cap = (cnt_q == CNT_W'(MAX_LEN - 1));
  // A vector ends on in_last or when the MAX_LEN-th beat is accepted.
  assign fin    = accept && (in_last || at_cap);

  // Next-state and beat counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d = fin ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE:    if (accept) state_d = fin ? HOLD : ACCUM;
      ACCUM:   if (fin) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && at_cap && !in_last) len_err_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < int'(NUM_ATTN_PES); i++) begin : g_lane
    logic signed [ACC_WIDTH-1:0] beat_sum;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] acc_d, acc_q;

    row_adder_tree #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_MACS   (NUM_MACS),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_tree (
      .prod (in_prod[i*LANE_W +: LANE_W]),
      .sum  (beat_sum)
    );

    assign base = first ? '0 : acc_q;

`ifdef ATTN_ACC_SAT_EN
    logic signed [63:0] wide;
    logic               sat_d, sat_q;

    // Saturating update; once a lane clips it holds its limit until the next vector.
    always_comb begin
      wide  = sat_add(64'(base), 64'(beat_sum), ACC_WIDTH);
      acc_d = ACC_WIDTH'(wide);
      sat_d = (wide != 64'(base + beat_sum));
      if (!first && sat_q) begin
        acc_d = acc_q;
        sat_d = 1'b1;
      end
    end

    // Sticky saturation flag, loaded with each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sat_q <= 1'b0;
      end else if (accept) begin
        sat_q <= sat_d;
      end
    end
`else
    // Wrapping two's-complement update.
    always_comb begin
      acc_d = base + beat_sum;
    end
`endif

    // Lane accumulator; loaded on the first beat, accumulated afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (accept) begin
        acc_q <= acc_d;
      end
    end

    assign out_acc[i*ACC_WIDTH +: ACC_WIDTH] = acc_q;
  end

endmodule

// File: tb/tb_attn_row_accum.sv
module tb_attn_row_accum;

  localparam int unsigned DW = 8;
  localparam int unsigned NM = 4;
  localparam int unsigned NP = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 16;
  localparam int unsigned ML = 4;
  localparam int unsigned PW = NM * NP * 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [PW-1:0] in_prod;
  logic          in_last;
  logic          out_ready;
  logic          in_ready, out_valid, len_err;
  logic [NP*AW-1:0] out_acc;
  logic          s_in_ready, s_out_valid, s_len_err;
  logic [NP*SW-1:0] s_out_acc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  attn_row_accum #(
    .DATA_WIDTH   (DW),
    .NUM_MACS     (NM),
    .NUM_ATTN_PES (NP),
    .ACC_WIDTH    (AW),
    .MAX_LEN      (ML)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .len_err   (len_err)
  );

  attn_row_accum #(
    .DATA_WIDTH   (DW),
    .NUM_MACS     (NM),
    .NUM_ATTN_PES (NP),
    .ACC_WIDTH    (SW),
    .MAX_LEN      (ML)
  ) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_acc   (s_out_acc),
    .len_err   (s_len_err)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] fill(input logic signed [15:0] v);
    logic [PW-1:0] r;
    for (int k = 0; k < int'(NM * NP); k++) r[k*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic signed [63:0] lane(input int i);
    logic signed [AW-1:0] v;
    v = out_acc[i*AW +: AW];
    return 64'(v);
  endfunction

  function automatic logic signed [63:0] slane(input int i);
    logic signed [SW-1:0] v;
    v = s_out_acc[i*SW +: SW];
    return 64'(v);
  endfunction

  // One beat presented for exactly one clock edge.
  task automatic beat(input logic [PW-1:0] p, input logic last);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_prod  = '0;
    in_last  = 1'b0;
  endtask

  task automatic check_lanes(input string tag, input logic signed [63:0] exp);
    for (int i = 0; i < int'(NP); i++) check(tag, lane(i), exp);
  endtask

  logic [PW-1:0] p;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_len_err", 64'(len_err), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check_lanes("rst_acc", 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat, all products +3.
    beat(fill(16'sd3), 1'b1);
    check("single_valid", 64'(out_valid), 1);
    check("single_in_ready", 64'(in_ready), 0);
    check_lanes("single_acc", 12);
    @(posedge clk);
    #1;
    check("single_done", 64'(out_valid), 0);
    check("single_ready_back", 64'(in_ready), 1);

    // Multi-beat signed on lane 0; other lanes zero.
    p = '0;
    p[15:0] = -16'sd5; p[31:16] = 16'sd2; p[47:32] = 16'sd1;
    beat(p, 1'b0);
    check("multi_no_valid", 64'(out_valid), 0);
    p = '0;
    p[15:0] = 16'sd100;
    beat(p, 1'b0);
    beat(fill(16'sd0) | {{(PW-64){1'b0}}, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1);
    check("multi_valid", 64'(out_valid), 1);
    check("multi_lane0", lane(0), 94);
    check("multi_lane1", lane(1), 0);
    check("multi_lane3", lane(3), 0);
    @(posedge clk);
    #1;

    // Backpressure: result held while consumer stalls, new beats refused.
    out_ready = 1'b0;
    beat(fill(16'sd1), 1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_prod  = fill(16'sd50);
      in_last  = 1'b1;
      check("bp_valid", 64'(out_valid), 1);
      check("bp_in_ready", 64'(in_ready), 0);
      check("bp_acc", lane(2), 4);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_release_valid", 64'(out_valid), 1);
    @(posedge clk);
    #1;
    check("bp_after_valid", 64'(out_valid), 0);
    check("bp_after_ready", 64'(in_ready), 1);
    check("bp_acc_untouched", lane(0), 4);

    // Exactly MAX_LEN beats with in_last on the last: no length error.
    for (int b = 0; b < int'(ML); b++) beat(fill(16'sd1), (b == int'(ML) - 1));
    check("full_valid", 64'(out_valid), 1);
    check_lanes("full_acc", 16);
    check("full_len_err", 64'(len_err), 0);
    @(posedge clk);
    #1;

    // Overrun: MAX_LEN beats without in_last.
    for (int b = 0; b < int'(ML); b++) beat(fill(16'sd1), 1'b0);
    check("ovr_valid", 64'(out_valid), 1);
    check_lanes("ovr_acc", 16);
    check("ovr_len_err", 64'(len_err), 1);
    @(posedge clk);
    #1;
    check("ovr_idle", 64'(out_valid), 0);
    check("ovr_len_err_sticky", 64'(len_err), 1);

    // Saturation / wrap on the 16-bit instance: MAC 0 of every lane = 16129.
    p = '0;
    for (int i = 0; i < int'(NP); i++) p[i*64 +: 16] = 16'sd16129;
    for (int b = 0; b < 3; b++) beat(p, (b == 2));
    check("sat_valid", 64'(s_out_valid), 1);
    check("sat_wide_ref", lane(0), 48387);
`ifdef ATTN_ACC_SAT_EN
    check("sat_lane0", slane(0), 32767);
    check("sat_lane3", slane(3), 32767);
`else
    check("wrap_lane0", slane(0), -17149);
    check("wrap_lane3", slane(3), -17149);
`endif
    @(posedge clk);
    #1;

    // Reset mid-vector discards the partial sum.
    beat(fill(16'sd1), 1'b0);
    beat(fill(16'sd1), 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 0);
    check("mid_rst_len_err", 64'(len_err), 0);
    check("mid_rst_acc", lane(0), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 1);
    check("mid_rst_no_valid", 64'(out_valid), 0);
    beat(fill(16'sd2), 1'b1);
    check("fresh_valid", 64'(out_valid), 1);
    check_lanes("fresh_acc", 8);
    check("fresh_len_err", 64'(len_err), 0);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
